iob_soc_pbus_reg_slice: RTL and testbench
=========================================

// Module: iob_soc_pbus_reg_slice
// PURPOSE
//   Pipeline/skid stage on the SoC peripheral bus, directly upstream of the pbus split.
//   Breaks the timing path from the CPU data port to the peripheral demux.
//   - Request path: 2-entry skid buffer; upstream ready_o depends on state only.
//   - Response path: one register stage for rvalid/rdata.
//   - Caps the number of reads in flight downstream at MAX_RD.
// PARAMETERS
//   ADDR_W   28  request address width (same on slave and master side)
//   DATA_W   32  wdata/rdata width; wstrb width is DATA_W/8
//   MAX_RD   4   max reads in flight downstream (1..7); counter width is 3 bits
// PORTS
//   clk_i              in   1         system clock, all logic on rising edge
//   rst_i              in   1         synchronous active-high reset
//   s_iob_valid_i      in   1         upstream request valid
//   s_iob_addr_i       in   ADDR_W    upstream address
//   s_iob_wdata_i      in   DATA_W    upstream write data
//   s_iob_wstrb_i      in   DATA_W/8  byte strobes; all-zero means read
//   s_iob_ready_o      out  1         request accepted when valid&ready
//   s_iob_rvalid_o     out  1         read response valid (single cycle)
//   s_iob_rdata_o      out  DATA_W    read response data
//   m_iob_valid_o      out  1         request to pbus split
//   m_iob_addr_o       out  ADDR_W    forwarded address
//   m_iob_wdata_o      out  DATA_W    forwarded write data
//   m_iob_wstrb_o      out  DATA_W/8  forwarded strobes
//   m_iob_ready_i      in   1         downstream accepts when valid&ready
//   m_iob_rvalid_i     in   1         downstream read response valid
//   m_iob_rdata_i      in   DATA_W    downstream read data
// BEHAVIOUR
//   Clocking and reset
//   - Single clock clk_i; reset rst_i is synchronous and active-high.
//   - Reset values: state=EMPTY, rd_cnt=0, m_iob_valid_o=0, s_iob_rvalid_o=0,
//     s_iob_rdata_o=0, s_iob_ready_o=1 (combinational from state).
//   - Reset mid-operation: buffered requests are dropped and rd_cnt is cleared.
//     A late m_iob_rvalid_i is still forwarded; rd_cnt saturates at 0.
//   Request buffer
//   - Two entries: head (presented on m_*) and skid. Each entry holds {addr, wdata, wstrb}.
//   - States: EMPTY, ONE (head valid), TWO (head + skid valid).
//   - s_iob_ready_o = (state != TWO). acc = s_valid & s_ready; pop = m_valid & m_ready.
//   - EMPTY: acc -> load head, go ONE.
//   - ONE: acc & !pop -> load skid, go TWO. acc & pop -> reload head, stay ONE.
//     !acc & pop -> EMPTY.
//   - TWO: pop -> skid moves to head, go ONE. No accept is possible in TWO.
//   - Order is strictly FIFO. m_* payload is stable while m_valid & !m_ready.
//   - Latency: a request accepted in cycle N is presented on m_* in cycle N+1 at the earliest.
//   Read throttle
//   - head_rd = (head wstrb == 0).
//   - m_iob_valid_o = (state != EMPTY) & !(head_rd & rd_cnt == MAX_RD).
//     The throttle uses the registered rd_cnt, so a one-cycle bubble on release is intended.
//   - rd_cnt next = rd_cnt + (pop & head_rd) - (m_iob_rvalid_i & rd_cnt != 0).
//     A simultaneous increment and decrement leaves rd_cnt unchanged.
//   - Writes are never throttled and do not count. Writes produce no rvalid.
//   Response path
//   - s_iob_rvalid_o <= m_iob_rvalid_i.
//   - s_iob_rdata_o <= m_iob_rdata_i when m_iob_rvalid_i; otherwise holds its value.
//   - Response latency is exactly 1 cycle. Back-to-back rvalids are passed through without loss.
// TESTING
//   - Reset: rst_i=1 for 2 cycles -> ready_o=1, m_valid_o=0, rvalid_o=0, rdata_o=0.
//   - Single write: addr=0x4000010, wdata=0xDEADBEEF, wstrb=0xF, m_ready=1
//     -> m_* shows the same values 1 cycle later for 1 cycle.
//   - Backpressure: m_ready=0, 3 back-to-back writes
//     -> first 2 accepted, ready_o=0 on the 3rd.
//     Release m_ready -> all 3 emerge in order with no duplicates.
//   - Throttle: MAX_RD=4, 5 reads, no rvalid -> exactly 4 m handshakes, 5th held.
//     One rvalid (rdata=0x12345678) -> s_rvalid_o/rdata_o 1 cycle later, 5th issues next cycle.
//   - Simultaneous: pop of a read and m_rvalid in the same cycle -> rd_cnt unchanged.
//   - Reset mid-flight: TWO state with rd_cnt=3, pulse rst_i -> EMPTY, rd_cnt=0.
//     A stray rvalid is forwarded and rd_cnt stays 0.

Source files
------------

// File: rtl/iob_soc_pbus_reg_slice.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iob_soc_pbus_reg_slice: peripheral-bus skid slice with read-issue throttle |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module iob_soc_pbus_reg_slice #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 32,
  parameter int MAX_RD = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                s_iob_valid_i,
  input  logic [ADDR_W-1:0]   s_iob_addr_i,
  input  logic [DATA_W-1:0]   s_iob_wdata_i,
  input  logic [DATA_W/8-1:0] s_iob_wstrb_i,
  output logic                s_iob_ready_o,
  output logic                s_iob_rvalid_o,
  output logic [DATA_W-1:0]   s_iob_rdata_o,
  output logic                m_iob_valid_o,
  output logic [ADDR_W-1:0]   m_iob_addr_o,
  output logic [DATA_W-1:0]   m_iob_wdata_o,
  output logic [DATA_W/8-1:0] m_iob_wstrb_o,
  input  logic                m_iob_ready_i,
  input  logic                m_iob_rvalid_i,
  input  logic [DATA_W-1:0]   m_iob_rdata_i
);

  localparam int         STRB_W   = DATA_W / 8;
  localparam int         REQ_W    = ADDR_W + DATA_W + STRB_W;
  localparam logic [2:0] MAX_RD_C = 3'(MAX_RD);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [REQ_W-1:0]    head_q, head_d;
  logic [REQ_W-1:0]    skid_q, skid_d;
  logic [2:0]          rd_cnt_q, rd_cnt_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                w_acc;
  logic                w_pop;
  logic                w_head_rd;
  logic [REQ_W-1:0]    w_req_in;

  assign w_req_in  = {s_iob_addr_i, s_iob_wdata_i, s_iob_wstrb_i};
  assign w_head_rd = (head_q[STRB_W-1:0] == '0);

  assign s_iob_ready_o = (state_q != ST_TWO);
  // Throttle looks at the registered count, so release costs one bubble.
  assign m_iob_valid_o = (state_q != ST_EMPTY) && !(w_head_rd && (rd_cnt_q == MAX_RD_C));
  assign {m_iob_addr_o, m_iob_wdata_o, m_iob_wstrb_o} = head_q;

  assign w_acc = s_iob_valid_i && s_iob_ready_o;
  assign w_pop = m_iob_valid_o && m_iob_ready_i;

  assign s_iob_rvalid_o = rvalid_q;
  assign s_iob_rdata_o  = rdata_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (w_acc) begin
          head_d  = w_req_in;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_acc && !w_pop) begin
          skid_d  = w_req_in;
          state_d = ST_TWO;
        end else if (w_acc && w_pop) begin
          head_d  = w_req_in;
        end else if (w_pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_pop) begin
          head_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Stray responses with nothing outstanding must not wrap the count.
  always_comb begin
    rd_cnt_d = rd_cnt_q
             + {2'b00, (w_pop && w_head_rd)}
             - {2'b00, (m_iob_rvalid_i && (rd_cnt_q != 3'd0))};
    rvalid_d = m_iob_rvalid_i;
    rdata_d  = m_iob_rvalid_i ? m_iob_rdata_i : rdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_EMPTY;
      head_q   <= '0;
      skid_q   <= '0;
      rd_cnt_q <= 3'd0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      skid_q   <= skid_d;
      rd_cnt_q <= rd_cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iob_soc_pbus_reg_slice.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_iob_soc_pbus_reg_slice: queue-model bench for the pbus register slice   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_iob_soc_pbus_reg_slice;

  localparam int MAX_RD = 4;

  typedef struct packed {
    logic [27:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        s_iob_valid_i = 1'b0;
  logic [27:0] s_iob_addr_i = '0;
  logic [31:0] s_iob_wdata_i = '0;
  logic [3:0]  s_iob_wstrb_i = '0;
  logic        s_iob_ready_o;
  logic        s_iob_rvalid_o;
  logic [31:0] s_iob_rdata_o;
  logic        m_iob_valid_o;
  logic [27:0] m_iob_addr_o;
  logic [31:0] m_iob_wdata_o;
  logic [3:0]  m_iob_wstrb_o;
  logic        m_iob_ready_i = 1'b0;
  logic        m_iob_rvalid_i = 1'b0;
  logic [31:0] m_iob_rdata_i = '0;

  iob_soc_pbus_reg_slice #(.ADDR_W(28), .DATA_W(32), .MAX_RD(MAX_RD)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .s_iob_valid_i  (s_iob_valid_i),
    .s_iob_addr_i   (s_iob_addr_i),
    .s_iob_wdata_i  (s_iob_wdata_i),
    .s_iob_wstrb_i  (s_iob_wstrb_i),
    .s_iob_ready_o  (s_iob_ready_o),
    .s_iob_rvalid_o (s_iob_rvalid_o),
    .s_iob_rdata_o  (s_iob_rdata_o),
    .m_iob_valid_o  (m_iob_valid_o),
    .m_iob_addr_o   (m_iob_addr_o),
    .m_iob_wdata_o  (m_iob_wdata_o),
    .m_iob_wstrb_o  (m_iob_wstrb_o),
    .m_iob_ready_i  (m_iob_ready_i),
    .m_iob_rvalid_i (m_iob_rvalid_i),
    .m_iob_rdata_i  (m_iob_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Model: requests waiting downstream, reads outstanding, last response.
  req_t        mq[$];
  int          m_out = 0;
  logic        exp_rvalid = 1'b0;
  logic [31:0] exp_rdata = '0;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          hs_cnt = 0;
  logic [27:0] hs_addr[$];
  logic        last_acc = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    logic e_ready, e_mvalid, head_rd, acc, pop, dec;
    #1;
    e_ready  = (mq.size() < 2);
    head_rd  = 1'b0;
    if (mq.size() > 0) head_rd = (mq[0].wstrb == 4'h0);
    e_mvalid = (mq.size() > 0) && !(head_rd && (m_out == MAX_RD));
    chk("ready", 64'(s_iob_ready_o), 64'(e_ready));
    chk("m_valid", 64'(m_iob_valid_o), 64'(e_mvalid));
    if (e_mvalid) begin
      chk("m_addr", 64'(m_iob_addr_o), 64'(mq[0].addr));
      chk("m_wdata", 64'(m_iob_wdata_o), 64'(mq[0].wdata));
      chk("m_wstrb", 64'(m_iob_wstrb_o), 64'(mq[0].wstrb));
    end
    chk("s_rvalid", 64'(s_iob_rvalid_o), 64'(exp_rvalid));
    chk("s_rdata", 64'(s_iob_rdata_o), 64'(exp_rdata));
    if (m_iob_valid_o && m_iob_ready_i) begin
      hs_cnt++;
      hs_addr.push_back(m_iob_addr_o);
    end
    acc = s_iob_valid_i && e_ready;
    pop = e_mvalid && m_iob_ready_i;
    last_acc = acc && !rst_i;
    if (rst_i) begin
      mq.delete();
      m_out = 0;
      exp_rvalid = 1'b0;
      exp_rdata = '0;
    end else begin
      dec = m_iob_rvalid_i && (m_out != 0);
      if (pop) begin
        if (head_rd) m_out++;
        void'(mq.pop_front());
      end
      if (dec) m_out--;
      if (acc) mq.push_back('{s_iob_addr_i, s_iob_wdata_i, s_iob_wstrb_i});
      exp_rvalid = m_iob_rvalid_i;
      if (m_iob_rvalid_i) exp_rdata = m_iob_rdata_i;
    end
    @(negedge clk_i);
  endtask

  task automatic send(input logic [27:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    s_iob_valid_i = 1'b1;
    s_iob_addr_i  = a;
    s_iob_wdata_i = d;
    s_iob_wstrb_i = s;
    do begin
      step();
      n++;
    end while (!last_acc && n < 50);
    chk("send_accepted", 64'(last_acc), 64'd1);
    s_iob_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int hs0;

  initial begin
    @(negedge clk_i);
    rst_i = 1'b1;
    idle(2);
    rst_i = 1'b0;
    chk("rst_ready", 64'(s_iob_ready_o), 64'd1);
    chk("rst_m_valid", 64'(m_iob_valid_o), 64'd0);
    chk("rst_rvalid", 64'(s_iob_rvalid_o), 64'd0);
    chk("rst_rdata", 64'(s_iob_rdata_o), 64'd0);

    // Single write passes through with one cycle of latency, for one cycle.
    m_iob_ready_i = 1'b1;
    send(28'h4000010, 32'hDEADBEEF, 4'hF);
    chk("wr_m_valid", 64'(m_iob_valid_o), 64'd1);
    chk("wr_m_addr", 64'(m_iob_addr_o), 64'h4000010);
    chk("wr_m_wdata", 64'(m_iob_wdata_o), 64'hDEADBEEF);
    chk("wr_m_wstrb", 64'(m_iob_wstrb_o), 64'hF);
    step();
    chk("wr_m_valid_gone", 64'(m_iob_valid_o), 64'd0);

    // Backpressure: two entries absorbed, third stalls, all drain in order.
    m_iob_ready_i = 1'b0;
    hs0 = hs_cnt;
    hs_addr.delete();
    send(28'h100, 32'h11, 4'hF);
    send(28'h104, 32'h22, 4'hF);
    chk("bp_ready_low", 64'(s_iob_ready_o), 64'd0);
    s_iob_valid_i = 1'b1;
    s_iob_addr_i  = 28'h108;
    step();
    m_iob_ready_i = 1'b1;
    send(28'h108, 32'h33, 4'hF);
    idle(4);
    chk("bp_hs_count", 64'(hs_cnt - hs0), 64'd3);
    chk("bp_order0", 64'(hs_addr.size() > 0 ? hs_addr[0] : 28'h0), 64'h100);
    chk("bp_order1", 64'(hs_addr.size() > 1 ? hs_addr[1] : 28'h0), 64'h104);
    chk("bp_order2", 64'(hs_addr.size() > 2 ? hs_addr[2] : 28'h0), 64'h108);

    // Throttle: five reads, four issue, the fifth waits for a response.
    hs0 = hs_cnt;
    for (int i = 0; i < 5; i++) send(28'h200 + 28'(4 * i), 32'h0, 4'h0);
    idle(3);
    chk("thr_hs_count", 64'(hs_cnt - hs0), 64'd4);
    chk("thr_held", 64'(m_iob_valid_o), 64'd0);
    m_iob_rvalid_i = 1'b1;
    m_iob_rdata_i  = 32'h12345678;
    step();
    m_iob_rvalid_i = 1'b0;
    chk("thr_rvalid", 64'(s_iob_rvalid_o), 64'd1);
    chk("thr_rdata", 64'(s_iob_rdata_o), 64'h12345678);
    chk("thr_release", 64'(m_iob_valid_o), 64'd1);
    step();
    chk("thr_hs_fifth", 64'(hs_cnt - hs0), 64'd5);
    chk("thr_rvalid_pulse", 64'(s_iob_rvalid_o), 64'd0);

    // Pop of a read coinciding with a response leaves the count unchanged.
    hs0 = hs_cnt;
    send(28'h300, 32'h0, 4'h0);
    m_iob_rvalid_i = 1'b1;
    m_iob_rdata_i  = 32'hCAFE0001;
    step();
    chk("sim_valid", 64'(m_iob_valid_o), 64'd1);
    m_iob_rdata_i  = 32'hCAFE0002;
    step();
    m_iob_rvalid_i = 1'b0;
    send(28'h304, 32'h0, 4'h0);
    send(28'h308, 32'h0, 4'h0);
    idle(3);
    chk("sim_hs_count", 64'(hs_cnt - hs0), 64'd2);
    chk("sim_held", 64'(m_iob_valid_o), 64'd0);

    // Reset while full with three reads outstanding.
    m_iob_ready_i  = 1'b0;
    m_iob_rvalid_i = 1'b1;
    step();
    m_iob_rvalid_i = 1'b0;
    send(28'h400, 32'h44, 4'hF);
    chk("mid_full", 64'(s_iob_ready_o), 64'd0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("mid_ready", 64'(s_iob_ready_o), 64'd1);
    chk("mid_m_valid", 64'(m_iob_valid_o), 64'd0);
    m_iob_rvalid_i = 1'b1;
    m_iob_rdata_i  = 32'hA5A5A5A5;
    step();
    m_iob_rvalid_i = 1'b0;
    chk("stray_rvalid", 64'(s_iob_rvalid_o), 64'd1);
    chk("stray_rdata", 64'(s_iob_rdata_o), 64'hA5A5A5A5);
    m_iob_ready_i = 1'b1;
    hs0 = hs_cnt;
    for (int i = 0; i < 5; i++) send(28'h500 + 28'(4 * i), 32'h0, 4'h0);
    idle(3);
    chk("post_rst_hs", 64'(hs_cnt - hs0), 64'd4);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst_i          = ($urandom_range(0, 499) == 0);
      s_iob_valid_i  = ($urandom_range(0, 2) != 0);
      s_iob_addr_i   = 28'($urandom);
      s_iob_wdata_i  = $urandom;
      s_iob_wstrb_i  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      m_iob_ready_i  = ($urandom_range(0, 3) != 0);
      m_iob_rvalid_i = ($urandom_range(0, 2) == 0);
      m_iob_rdata_i  = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
